// File: rtl/i2c_codec_sequencer.sv
// Codec register sequencer: walks a fixed {reg,cmd} table over an I2C write controller,
// retrying NACKed commands and re-sending only the volume registers when volume changes.
module i2c_codec_sequencer #(
  parameter int         NUM_CMD   = 9,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3,
  parameter int         VOL_W     = 2,
  parameter logic [8:0] VOL_BASE  = 9'h049,
  parameter logic [8:0] VOL_STEP  = 9'h010,
  parameter int         VOL_L_IDX = 3,
  parameter int         VOL_R_IDX = 4
) (
  input  logic             clk_i2c,
  input  logic             reset,
  input  logic             start,
  input  logic [VOL_W-1:0] volume,
  output logic [23:0]      i2c_data,
  output logic             i2c_go,
  input  logic             i2c_end,
  input  logic [2:0]       i2c_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       cmd_idx
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, NEXT, DONE, ERROR} state_t;

  state_t           state_q, state_d;
  logic [23:0]      data_q, data_d;
  logic             go_q, go_d;
  logic [3:0]       idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic             vonly_q, vonly_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [8:0]       vol_code;

  assign vol_code = VOL_BASE + VOL_STEP * 9'(vol_q);

  // {reg[6:0], cmd[8:0]} for each table slot; the volume slots take the latched code.
  function automatic logic [15:0] entry(input logic [3:0] idx, input logic [8:0] vc);
    case (idx)
      4'd0:    entry = {7'h0F, 9'h000};
      4'd1:    entry = {7'h06, 9'h000};
      4'd2:    entry = {7'h08, 9'h002};
      4'd3:    entry = {7'h02, vc};
      4'd4:    entry = {7'h03, vc};
      4'd5:    entry = {7'h07, 9'h001};
      4'd6:    entry = {7'h09, 9'h001};
      4'd7:    entry = {7'h04, 9'h016};
      4'd8:    entry = {7'h05, 9'h006};
      default: entry = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      go_q    <= 1'b0;
      idx_q   <= '0;
      retry_q <= '0;
      vol_q   <= '0;
      vonly_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      go_q    <= go_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      vol_q   <= vol_d;
      vonly_q <= vonly_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    go_d    = go_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    vol_d   = vol_q;
    vonly_d = vonly_q;
    case (state_q)
      IDLE: begin
        vol_d   = volume;
        idx_d   = '0;
        retry_d = '0;
        vonly_d = 1'b0;
        state_d = LOAD;
      end
      LOAD: begin
        data_d  = {DEV_ADDR, 1'b0, entry(idx_q, vol_code)};
        go_d    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (i2c_end) begin
          go_d = 1'b0;
          if (i2c_ack == 3'b000) begin
            retry_d = '0;
            state_d = NEXT;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = LOAD;
          end else begin
            state_d = ERROR;
          end
        end
      end
      NEXT: begin
        if (vonly_q) begin
          if (idx_q == 4'(VOL_R_IDX)) begin
            state_d = DONE;
          end else begin
            idx_d   = 4'(VOL_R_IDX);
            state_d = LOAD;
          end
        end else if (idx_q == 4'(NUM_CMD - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = LOAD;
        end
      end
      DONE: begin
        // A start request outranks a simultaneous volume change.
        if (start) begin
          state_d = IDLE;
        end else if (volume != vol_q) begin
          vol_d   = volume;
          vonly_d = 1'b1;
          idx_d   = 4'(VOL_L_IDX);
          state_d = LOAD;
        end
      end
      ERROR: begin
        go_d = 1'b0;
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  assign i2c_data = data_q;
  assign i2c_go   = go_q;
  assign cmd_idx  = idx_q;
  assign done     = done_q;
  assign error    = error_q;
  assign busy     = (state_q != DONE) && (state_q != ERROR);

endmodule

// File: doc/i2c_codec_sequencer.md
I2C_CODEC_SEQUENCER -- requirements
Module: i2c_codec_sequencer

Interface
REQ-001 Parameter NUM_CMD, default 9: number of table entries sent per full sequence, legal range 1..16.
REQ-002 Parameter DEV_ADDR, default 7'h1A: 7-bit I2C slave address; the R/W bit is always 0 (write).
REQ-003 Parameter MAX_RETRY, default 3: maximum re-sends of one command after a NACK.
REQ-004 Parameter VOL_W, default 2: width of the volume input.
REQ-005 Parameter VOL_BASE, default 9'h049, and VOL_STEP, default 9'h010: volume code = VOL_BASE + volume*VOL_STEP, truncated to 9 bits.
REQ-006 Parameter VOL_L_IDX, default 3, and VOL_R_IDX, default 4: table indices that carry the left and right volume.
REQ-007 clk_i2c  in  1  I2C-rate controller clock (10 kHz); all logic is on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  single-cycle request to rerun the full sequence.
REQ-010 volume  in  VOL_W  requested volume step; it may change at any time.
REQ-011 i2c_data  out  24  {DEV_ADDR,1'b0, reg[6:0], cmd[8:0]} sent to the I2C controller.
REQ-012 i2c_go  out  1  transfer request to the I2C controller.
REQ-013 i2c_end  in  1  transfer-complete flag from the I2C controller.
REQ-014 i2c_ack  in  3  per-byte acknowledge status; any bit set means NACK.
REQ-015 busy  out  1  high while a sequence or a volume update is in progress.
REQ-016 done  out  1  high when the last sequence completed without error.
REQ-017 error  out  1  high when a command exhausted its retries.
REQ-018 cmd_idx  out  4  index of the current or last command.

Function
REQ-019 The internal table {reg,cmd} SHALL be: 0:{0F,000}, 1:{06,000}, 2:{08,002}, 3:{02,vol}, 4:{03,vol}, 5:{07,001}, 6:{09,001}, 7:{04,016}, 8:{05,006}; indices 9..15 SHALL be {00,000}.
REQ-020 For the volume entries, vol SHALL be computed from vol_q, a register loaded from volume at the start of each sequence and each volume update, and never directly from the live volume input.
REQ-021 The state machine SHALL have the states IDLE, LOAD, WAIT, NEXT, DONE and ERROR.
REQ-022 IDLE SHALL latch vol_q, clear cmd_idx, retry_cnt and the volume-only mode flag, and go to LOAD on the next cycle.
REQ-023 LOAD SHALL register i2c_data from the entry at cmd_idx, set i2c_go to 1 and go to WAIT; i2c_data and i2c_go change on the same edge.
REQ-024 WAIT SHALL hold i2c_go and i2c_data steady until i2c_end is 1, then clear i2c_go on that edge.
REQ-025 On exit from WAIT with i2c_ack == 0, the state machine SHALL clear retry_cnt and go to NEXT.
REQ-026 On exit from WAIT with any i2c_ack bit set and retry_cnt < MAX_RETRY, the state machine SHALL increment retry_cnt and go to LOAD, so i2c_go is low for at least one cycle.
REQ-027 On exit from WAIT with any i2c_ack bit set and retry_cnt == MAX_RETRY, the state machine SHALL go to ERROR.
REQ-028 NEXT in full mode SHALL go to DONE if cmd_idx == NUM_CMD-1, and otherwise increment cmd_idx and go to LOAD.
REQ-029 NEXT in volume-only mode SHALL go to DONE if cmd_idx == VOL_R_IDX, and otherwise set cmd_idx to VOL_R_IDX and go to LOAD.
REQ-030 DONE SHALL hold done=1; on start it SHALL go to IDLE (full rerun).
REQ-031 In DONE, if start is 0 and volume != vol_q, the block SHALL latch vol_q, set the volume-only flag, set cmd_idx to VOL_L_IDX and go to LOAD; start has priority over a volume change on the same cycle.
REQ-032 ERROR SHALL hold error=1 and i2c_go=0, ignore volume changes, and go to IDLE on start.
REQ-033 start SHALL be ignored in IDLE, LOAD, WAIT and NEXT; a volume change during a sequence SHALL be serviced from DONE afterwards.
REQ-034 busy SHALL be 1 in IDLE, LOAD, WAIT and NEXT, and 0 in DONE and ERROR.
REQ-035 done and error SHALL be registered, mutually exclusive, and cleared on entry to IDLE.
REQ-036 retry_cnt SHALL be wide enough for MAX_RETRY, with no wrap-around.

Reset
REQ-037 While reset=1 at a clock edge, the block SHALL force: state=IDLE, i2c_go=0, i2c_data=0, cmd_idx=0, retry_cnt=0, busy=1, done=0, error=0, volume-only flag=0.
REQ-038 Reset asserted mid-transfer SHALL drop i2c_go on that edge, and the sequence SHALL restart from index 0 after release.
REQ-039 After reset release, the first i2c_go SHALL rise 2 cycles later (IDLE, then LOAD).

Verification
REQ-040 Full sequence: reset, volume=2, ACK=0 on every transfer -> exactly 9 transfers in table order; index 3 data=24'h340469; done=1, busy=0, cmd_idx=8.
REQ-041 Retry: NACK (i2c_ack=3'b001) on the first 2 attempts of index 5 -> index 5 is sent 3 times with go low at least 1 cycle between attempts; the sequence completes with done=1.
REQ-042 Exhaustion: persistent NACK on index 2 -> 4 attempts, then error=1, go=0, cmd_idx=2; a start pulse restarts from index 0.
REQ-043 Volume update: in DONE change volume 3->0 -> exactly 2 transfers, 24'h340449 then 24'h340649, then DONE.
REQ-044 Conflict: volume change during index 6 plus start during WAIT -> start is ignored; after index 8 the block performs a volume-only update.
REQ-045 Mid-run reset: reset during WAIT of index 4 -> go=0 on that edge; after release, a fresh sequence starts at index 0.
